max_scan: RTL
=============

MAX_SCAN -- requirements
Module: max_scan

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port master_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port global_rst  input  1  synchronous clear, active-high, same effect as reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; opens a new frame scan.
REQ-005 SHALL have port din  input  8  unsigned sample.
REQ-006 SHALL have port din_valid  input  1  din is valid this cycle.
REQ-007 SHALL have port din_last  input  1  qualifies the final sample of a frame when din_valid=1.
REQ-008 SHALL have port din_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port max_out  output  8  frame maximum, feeds the downstream max register.
REQ-010 SHALL have port max_idx  output  8  position of the maximum within its frame.
REQ-011 SHALL have port max_valid  output  1  max_out/max_idx valid and stable.
REQ-012 SHALL have port max_ack  input  1  consumer has taken the result.
REQ-013 SHALL have port busy  output  1  high in SCAN or HOLD.

Function
REQ-014 SHALL implement three states: IDLE, SCAN, HOLD.
REQ-015 IDLE: din_ready=0, max_valid=0; start=1 -> SCAN next cycle, running max cleared to 8'h00, index counter cleared to 0, first-sample flag set.
REQ-016 SCAN: din_ready=1; a sample is accepted only when din_valid=1 and din_ready=1.
REQ-017 On an accepted sample: if first-sample flag set or din > running max (unsigned, strict), running max <= din and running index <= counter; counter <= counter+1; first-sample flag cleared.
REQ-018 Ties SHALL keep the earliest index (strict greater-than compare).
REQ-019 Counter SHALL be 8 bits and wrap 255 -> 0; frames longer than 256 samples report index modulo 256.
REQ-020 Accepted sample with din_last=1 -> HOLD next cycle; the last sample participates in the compare.
REQ-021 Latency: max_out/max_idx/max_valid SHALL be valid the cycle after the din_last handshake.
REQ-022 HOLD: din_ready=0, max_valid=1; max_out and max_idx SHALL NOT change while in HOLD.
REQ-023 HOLD with max_ack=1 -> IDLE next cycle; max_valid deasserts that same next cycle.
REQ-024 HOLD with max_ack=1 and start=1 same cycle -> SCAN directly, with clears per REQ-015.
REQ-025 start SHALL be ignored in SCAN; max_ack SHALL be ignored outside HOLD.
REQ-026 max_out and max_idx SHALL retain their last HOLD values in IDLE until the next frame's first accepted sample.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 master_rst_n=0 SHALL asynchronously force IDLE, max_out=8'h00, max_idx=8'h00, max_valid=0, din_ready=0, busy=0, counter=0.
REQ-029 global_rst=1 SHALL produce the same values synchronously at the next rising edge, overriding all other inputs.
REQ-030 Reset mid-SCAN or mid-HOLD SHALL discard the frame; no max_valid is produced for it.

Configuration
REQ-031 Macro MAX_SCAN_INDEX_EN SHALL gate index tracking.
REQ-032 With MAX_SCAN_INDEX_EN defined: max_idx behaves per REQ-017..REQ-019.
REQ-033 Without MAX_SCAN_INDEX_EN: max_idx SHALL be tied to 8'h00 and no index or counter registers SHALL be synthesised; all other behaviour unchanged.

Verification
REQ-034 Reset then start, frame 3,9,4,9(last) -> after last handshake, max_valid=1, max_out=9, max_idx=1; ack -> IDLE.
REQ-035 start, single sample 8'h00 with din_last -> max_out=0, max_idx=0, max_valid=1 next cycle.
REQ-036 start, 300 samples value=i mod 256 but sample 260 =8'hFF... all ≤255: max_out=8'hFF, max_idx=255 (first 8'hFF, tie kept); counter wrap checked on 300-sample frame with only sample 270 =8'hFF -> max_idx=14.
REQ-037 din_valid toggled 1/0 each cycle during frame 5,7,2(last) -> only valid cycles counted, max_out=7, max_idx=1; max held stable over 5 cycles without ack.
REQ-038 HOLD with max_ack=1 and start=1 same cycle -> next cycle SCAN, max_valid=0, din_ready=1.
REQ-039 master_rst_n pulsed low mid-SCAN (asynchronously, between edges) -> outputs zero immediately; subsequent frame 1,2(last) -> max_out=2, max_idx=1.

Source files
------------

// File: rtl/max_scan.sv
// Frame maximum scanner: tracks the largest unsigned sample of a framed stream and holds it
// until acknowledged. Define MAX_SCAN_INDEX_EN to also track the position of the maximum.
module max_scan (
  input  logic       clk,
  input  logic       master_rst_n,
  input  logic       global_rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [7:0] max_out,
  output logic [7:0] max_idx,
  output logic       max_valid,
  input  logic       max_ack,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  state_e state_q, state_d;

  logic       accept;
  logic       frame_open;
  logic       take;
  logic       first_q;
  logic [7:0] max_q;

  assign accept     = (state_q == StScan) && din_valid;
  assign frame_open = start && ((state_q == StIdle) || ((state_q == StHold) && max_ack));
  assign take       = accept && (first_q || (din > max_q));

  // State register
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      state_q <= StIdle;
    end else if (global_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StScan;
      end
      StScan: begin
        if (accept && din_last) state_d = StHold;
      end
      StHold: begin
        if (max_ack) state_d = start ? StScan : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    din_ready = (state_q == StScan);
    max_valid = (state_q == StHold);
    busy      = (state_q != StIdle);
  end

  // The first-sample flag makes the first accepted sample win unconditionally, which is
  // equivalent to clearing the running max while leaving the previous result visible.
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      first_q <= 1'b0;
      max_q   <= 8'h00;
    end else if (global_rst) begin
      first_q <= 1'b0;
      max_q   <= 8'h00;
    end else begin
      if (frame_open) begin
        first_q <= 1'b1;
      end else if (accept) begin
        first_q <= 1'b0;
      end
      if (take) begin
        max_q <= din;
      end
    end
  end

  assign max_out = max_q;

`ifdef MAX_SCAN_INDEX_EN
  logic [7:0] cnt_q;
  logic [7:0] idx_q;

  // Counter wraps naturally at 8 bits, so long frames report index modulo 256.
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      cnt_q <= 8'h00;
      idx_q <= 8'h00;
    end else if (global_rst) begin
      cnt_q <= 8'h00;
      idx_q <= 8'h00;
    end else begin
      if (frame_open) begin
        cnt_q <= 8'h00;
      end else if (accept) begin
        cnt_q <= cnt_q + 8'h01;
      end
      if (take) begin
        idx_q <= cnt_q;
      end
    end
  end

  assign max_idx = idx_q;
`else
  assign max_idx = 8'h00;
`endif

endmodule
